register_access_ctrl: RTL and testbench

Requester-side controller for the 8x32 single-port register RAM: accepts single- or multi-register (mask-driven, MOVEM-style) read/write requests from the core, sequences them onto the RAM's address/byte-enable/write-enable port, and returns read data with size extension. It sits between the execution microcode and the register RAM and hides the RAM's one-cycle registered-address read latency behind valid/ready handshakes.

---
 rtl/register_access_ctrl_pkg.sv | 34 +++
 rtl/register_access_ctrl_mask_encoder.sv | 22 ++
 rtl/register_access_ctrl.sv | 139 +++++++++++++
 tb/tb_register_access_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_access_ctrl_pkg.sv
// Shared definitions for register_access_ctrl: transfer size encodings,
// controller state enum and per-size RAM byte-enable patterns.
package register_access_ctrl_pkg;

    // Transfer size encodings. The fourth code (2'b11) is handled as long.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_WORD = 2'b01;
    localparam logic [1:0] SIZE_LONG = 2'b10;

    // RAM byte-lane enables for each transfer size.
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_WORD = 4'b0011;
    localparam logic [3:0] BE_LONG = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_ADDR,
        ST_READ_DATA,
        ST_DONE
    } state_t;

    // Map a transfer size to its byte-lane enable pattern.
    function automatic logic [3:0] size_to_be(input logic [1:0] size);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = BE_BYTE;
            SIZE_WORD: be = BE_WORD;
            default:   be = BE_LONG;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/register_access_ctrl_mask_encoder.sv
// register_mask_encoder: lowest-set-bit priority encoder over the 8-bit
// register mask. Produces the index of the lowest set bit and an any-set flag.
module register_mask_encoder (
    input  logic [7:0] mask,
    output logic [2:0] index,
    output logic       any_set
);

    // Scan from the top bit down so the lowest set bit is written last and wins.
    always_comb begin
        // NOTE: every combinational output gets a default first; otherwise a path
        // that never assigns it infers a latch.
        index   = 3'd0;
        any_set = |mask;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                index = 3'(i);
            end
        end
    end

endmodule

// File: rtl/register_access_ctrl.sv
// register_access_ctrl: sequences single- or multi-register (mask-driven)
// read/write requests onto the 8x32 single-port register RAM and returns read
// data with size extension. The RAM registers its address, so each read takes
// an address cycle (READ_ADDR) followed by a data cycle (READ_DATA).
// Optional feature: define REGISTER_ACCESS_SIGN_EXTEND_EN to sign-extend byte
// and word reads; otherwise they are zero-extended.
module register_access_ctrl
    import register_access_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [7:0]  req_mask,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    input  logic [31:0] wdata,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic [2:0]  rd_reg,
    output logic        done,
    output logic [2:0]  ram_address,
    output logic [3:0]  ram_byte_enable,
    output logic        ram_write_enable,
    output logic [31:0] ram_data_input,
    input  logic [31:0] ram_data_output
);

    state_t      state_q, state_d;
    logic [7:0]  mask_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic [2:0]  cur_idx;
    logic        mask_any;
    logic [7:0]  mask_rest;
    logic        accept;
    logic        xfer;

    register_mask_encoder u_mask_encoder (
        .mask    (mask_q),
        .index   (cur_idx),
        .any_set (mask_any)
    );

    // Mask left once the register currently being served is retired.
    assign mask_rest = mask_q & ~(8'd1 << cur_idx);

    // Extend raw RAM data to 32 bits according to the latched transfer size.
    function automatic logic [31:0] extend_read(input logic [31:0] raw, input logic [1:0] size);
        logic [31:0] ext;
        case (size)
`ifdef REGISTER_ACCESS_SIGN_EXTEND_EN
            SIZE_BYTE: ext = {{24{raw[7]}}, raw[7:0]};
            SIZE_WORD: ext = {{16{raw[15]}}, raw[15:0]};
`else
            SIZE_BYTE: ext = {24'd0, raw[7:0]};
            SIZE_WORD: ext = {16'd0, raw[15:0]};
`endif
            default:   ext = raw;
        endcase
        return ext;
    endfunction

    // State register and request latches; reset discards any in-flight request.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= ST_IDLE;
            mask_q  <= 8'd0;
            write_q <= 1'b0;
            size_q  <= SIZE_LONG;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mask_q  <= req_mask;
                write_q <= req_write;
                size_q  <= req_size;
            end else if (xfer) begin
                mask_q <= mask_rest;
            end
        end
    end

    // Next-state decode and handshake/RAM outputs for the current state.
    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        wdata_ready      = 1'b0;
        rd_valid         = 1'b0;
        rd_data          = 32'd0;
        rd_reg           = 3'd0;
        done             = 1'b0;
        ram_write_enable = 1'b0;
        accept           = 1'b0;
        xfer             = 1'b0;
        ram_address      = (state_q == ST_IDLE) ? 3'd0 : cur_idx;
        ram_byte_enable  = size_to_be(size_q);
        ram_data_input   = wdata;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid) begin
                    if (req_mask == 8'd0) state_d = ST_DONE;
                    else if (req_write)   state_d = ST_WRITE;
                    else                  state_d = ST_READ_ADDR;
                end
            end
            ST_WRITE: begin
                wdata_ready      = 1'b1;
                ram_write_enable = wdata_valid & mask_any;
                xfer             = ram_write_enable;
                if (xfer && mask_rest == 8'd0) state_d = ST_DONE;
            end
            ST_READ_ADDR: begin
                state_d = ST_READ_DATA;
            end
            ST_READ_DATA: begin
                rd_valid = 1'b1;
                rd_reg   = cur_idx;
                rd_data  = extend_read(ram_data_output, size_q);
                xfer     = rd_ready;
                if (rd_ready) state_d = (mask_rest == 8'd0) ? ST_DONE : ST_READ_ADDR;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // write_q only steers the IDLE branch choice at accept; keep it observable.
        if (state_q == ST_WRITE && !write_q) ram_write_enable = 1'b0;
    end

endmodule

// File: tb/tb_register_access_ctrl.sv
// Self-checking directed bench for register_access_ctrl with a behavioural
// 8x32 single-port RAM (registered read address, byte-lane writes).
module tb_register_access_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_size;
    logic [7:0]  req_mask;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic [2:0]  rd_reg;
    logic        done;
    logic [2:0]  ram_address;
    logic [3:0]  ram_byte_enable;
    logic        ram_write_enable;
    logic [31:0] ram_data_input, ram_data_output;

    int total = 0;
    int bad   = 0;

    register_access_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_mask         (req_mask),
        .wdata_valid      (wdata_valid),
        .wdata_ready      (wdata_ready),
        .wdata            (wdata),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_data          (rd_data),
        .rd_reg           (rd_reg),
        .done             (done),
        .ram_address      (ram_address),
        .ram_byte_enable  (ram_byte_enable),
        .ram_write_enable (ram_write_enable),
        .ram_data_input   (ram_data_input),
        .ram_data_output  (ram_data_output)
    );

    always #5 clock = ~clock;

    // Register RAM model: byte-lane writes, address registered for reads.
    logic [31:0] mem [8];
    logic [2:0]  addr_q = 3'd0;
    always @(posedge clock) begin
        if (ram_write_enable) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byte_enable[b]) mem[ram_address][b*8 +: 8] <= ram_data_input[b*8 +: 8];
            end
        end
        addr_q <= ram_address;
    end
    assign ram_data_output = mem[addr_q];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 0; req_write = 0; req_size = 2'b10; req_mask = 0;
        wdata_valid = 0; wdata = 0; rd_ready = 0;
        #12;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (wdata_ready !== 1'b0 || rd_valid !== 1'b0 || ram_write_enable !== 1'b0) begin
            bad++; $display("FAIL reset_handshakes got wr=%b rv=%b we=%b exp=000", wdata_ready, rd_valid, ram_write_enable); end
        total++; if (rd_data !== 32'd0 || rd_reg !== 3'd0 || ram_address !== 3'd0) begin
            bad++; $display("FAIL reset_data got rd_data=%h rd_reg=%0d addr=%0d exp=0", rd_data, rd_reg, ram_address); end
        total++; if (ram_byte_enable !== 4'b1111) begin bad++; $display("FAIL reset_be got=%b exp=1111", ram_byte_enable); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_single_long_write;
        tick;
        req_valid = 1; req_write = 1; req_size = 2'b10; req_mask = 8'h04;
        wdata_valid = 1; wdata = 32'hDEADBEEF;
        @(negedge clock);
        total++; if (req_ready !== 1'b1 || ram_write_enable !== 1'b0) begin
            bad++; $display("FAIL slw_idle got rr=%b we=%b exp rr=1 we=0", req_ready, ram_write_enable); end
        tick;
        req_valid = 0;
        @(negedge clock);
        total++; if (ram_write_enable !== 1'b1 || ram_address !== 3'd2 || ram_byte_enable !== 4'hF ||
                     wdata_ready !== 1'b1 || ram_data_input !== 32'hDEADBEEF) begin
            bad++; $display("FAIL slw_write got we=%b addr=%0d be=%b wr=%b din=%h exp we=1 addr=2 be=1111 wr=1 din=deadbeef",
                            ram_write_enable, ram_address, ram_byte_enable, wdata_ready, ram_data_input); end
        tick;
        wdata_valid = 0;
        @(negedge clock);
        total++; if (done !== 1'b1 || ram_write_enable !== 1'b0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL slw_done got done=%b we=%b rr=%b exp 1 0 0", done, ram_write_enable, req_ready); end
        total++; if (mem[2] !== 32'hDEADBEEF) begin bad++; $display("FAIL slw_mem got=%h exp=deadbeef", mem[2]); end
        tick;
        @(negedge clock);
        total++; if (done !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL slw_idle_after got done=%b rr=%b exp done=0 rr=1", done, req_ready); end
    endtask

    task automatic test_multi_write_gaps;
        logic        v_seq  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] d_seq  [4] = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0007};
        logic [2:0]  a_seq  [4] = '{3'd0, 3'd1, 3'd1, 3'd7};
        req_valid = 1; req_write = 1; req_size = 2'b01; req_mask = 8'b1000_0011; wdata_valid = 0;
        tick;
        req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            wdata_valid = v_seq[i]; wdata = d_seq[i];
            @(negedge clock);
            total++; if (ram_write_enable !== v_seq[i] || ram_address !== a_seq[i] || ram_byte_enable !== 4'b0011) begin
                bad++; $display("FAIL mw_cycle%0d got we=%b addr=%0d be=%b exp we=%b addr=%0d be=0011",
                                i, ram_write_enable, ram_address, ram_byte_enable, v_seq[i], a_seq[i]); end
            tick;
        end
        wdata_valid = 0;
        @(negedge clock);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL mw_done got=%b exp=1", done); end
        total++; if (mem[0][15:0] !== 16'h0001 || mem[1][15:0] !== 16'h0003 || mem[7][15:0] !== 16'h0007) begin
            bad++; $display("FAIL mw_mem got r0=%h r1=%h r7=%h exp 0001 0003 0007", mem[0][15:0], mem[1][15:0], mem[7][15:0]); end
        tick;
    endtask

    task automatic test_byte_read;
        logic [31:0] exp_data;
`ifdef REGISTER_ACCESS_SIGN_EXTEND_EN
        exp_data = 32'hFFFFFFF0;
`else
        exp_data = 32'h000000F0;
`endif
        req_valid = 1; req_write = 1; req_size = 2'b10; req_mask = 8'h20; wdata_valid = 1; wdata = 32'h000000F0;
        tick;
        req_valid = 0;
        tick;
        wdata_valid = 0;
        tick;
        req_valid = 1; req_write = 0; req_size = 2'b00; req_mask = 8'h20; rd_ready = 1;
        @(negedge clock);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL br_ready got=%b exp=1", req_ready); end
        tick;
        req_valid = 0;
        @(negedge clock);
        total++; if (rd_valid !== 1'b0 || ram_address !== 3'd5 || ram_write_enable !== 1'b0 || ram_byte_enable !== 4'b0001) begin
            bad++; $display("FAIL br_addr got rv=%b addr=%0d we=%b be=%b exp rv=0 addr=5 we=0 be=0001",
                            rd_valid, ram_address, ram_write_enable, ram_byte_enable); end
        tick;
        @(negedge clock);
        total++; if (rd_valid !== 1'b1 || rd_reg !== 3'd5 || rd_data !== exp_data) begin
            bad++; $display("FAIL br_data got rv=%b reg=%0d data=%h exp rv=1 reg=5 data=%h", rd_valid, rd_reg, rd_data, exp_data); end
        tick;
        rd_ready = 0;
        @(negedge clock);
        total++; if (done !== 1'b1 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL br_done got done=%b rv=%b exp 1 0", done, rd_valid); end
        tick;
    endtask

    task automatic test_read_backpressure;
        logic [31:0] exp1;
`ifdef REGISTER_ACCESS_SIGN_EXTEND_EN
        exp1 = 32'hFFFF8001;
`else
        exp1 = 32'h00008001;
`endif
        req_valid = 1; req_write = 1; req_size = 2'b10; req_mask = 8'h03; wdata_valid = 1; wdata = 32'h12345678;
        tick;
        req_valid = 0;
        tick;
        wdata = 32'h00008001;
        tick;
        wdata_valid = 0;
        tick;
        req_valid = 1; req_write = 0; req_size = 2'b01; req_mask = 8'h03; rd_ready = 0;
        tick;
        req_valid = 0;
        tick;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++; if (rd_valid !== 1'b1 || rd_reg !== 3'd0 || rd_data !== 32'h00005678 || req_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d got rv=%b reg=%0d data=%h rr=%b exp rv=1 reg=0 data=00005678 rr=0",
                                i, rd_valid, rd_reg, rd_data, req_ready); end
            tick;
        end
        rd_ready = 1;
        tick;
        @(negedge clock);
        total++; if (rd_valid !== 1'b0 || ram_address !== 3'd1) begin
            bad++; $display("FAIL bp_readdr got rv=%b addr=%0d exp rv=0 addr=1", rd_valid, ram_address); end
        tick;
        @(negedge clock);
        total++; if (rd_valid !== 1'b1 || rd_reg !== 3'd1 || rd_data !== exp1) begin
            bad++; $display("FAIL bp_reg1 got rv=%b reg=%0d data=%h exp rv=1 reg=1 data=%h", rd_valid, rd_reg, rd_data, exp1); end
        tick;
        rd_ready = 0;
        @(negedge clock);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b exp=1", done); end
        tick;
    endtask

    task automatic test_zero_mask;
        req_valid = 1; req_write = 0; req_size = 2'b10; req_mask = 8'h00;
        tick;
        req_valid = 0;
        @(negedge clock);
        total++; if (done !== 1'b1 || ram_write_enable !== 1'b0 || rd_valid !== 1'b0 || ram_address !== 3'd0) begin
            bad++; $display("FAIL zm_done got done=%b we=%b rv=%b addr=%0d exp 1 0 0 0", done, ram_write_enable, rd_valid, ram_address); end
        tick;
        @(negedge clock);
        total++; if (done !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL zm_idle got done=%b rr=%b exp done=0 rr=1", done, req_ready); end
    endtask

    task automatic test_reset_mid_write;
        tick;
        req_valid = 1; req_write = 1; req_size = 2'b10; req_mask = 8'h07; wdata_valid = 1; wdata = 32'h55555555;
        tick;
        req_valid = 0;
        tick;
        wdata = 32'h66666666;
        @(negedge clock);
        total++; if (ram_write_enable !== 1'b1 || ram_address !== 3'd1) begin
            bad++; $display("FAIL rst_pre got we=%b addr=%0d exp we=1 addr=1", ram_write_enable, ram_address); end
        #2 reset = 1'b1;
        #1;
        total++; if (ram_write_enable !== 1'b0 || req_ready !== 1'b1 || wdata_ready !== 1'b0 || ram_address !== 3'd0) begin
            bad++; $display("FAIL rst_async got we=%b rr=%b wr=%b addr=%0d exp 0 1 0 0",
                            ram_write_enable, req_ready, wdata_ready, ram_address); end
        wdata_valid = 0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            @(negedge clock);
            total++; if (done !== 1'b0 || req_ready !== 1'b1) begin
                bad++; $display("FAIL rst_after%0d got done=%b rr=%b exp done=0 rr=1", i, done, req_ready); end
        end
        total++; if (mem[0] !== 32'h55555555 || mem[1] !== 32'h00008001) begin
            bad++; $display("FAIL rst_mem got r0=%h r1=%h exp 55555555 00008001", mem[0], mem[1]); end
    endtask

    initial begin
        test_reset;
        test_single_long_write;
        test_multi_write_gaps;
        test_byte_read;
        test_read_backpressure;
        test_zero_mask;
        test_reset_mid_write;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
